// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the core and the iterative RV32M mul/div unit.
// start is taken only in IDLE; done is a one-cycle valid with no ready, and busy blocks new requests.
interface muldiv_unit_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  start;
    logic                  kill;
    logic [2:0]            funct3;
    logic [XLEN-1:0]       operand_a;
    logic [XLEN-1:0]       operand_b;
    logic [REG_ADDR_W-1:0] dest_reg;
    logic                  busy;
    logic                  done;
    logic [XLEN-1:0]       result;
    logic [REG_ADDR_W-1:0] write_reg;
    logic                  write_en;
    logic [XLEN-1:0]       write_data;

    modport master (
        output start, kill, funct3, operand_a, operand_b, dest_reg,
        input  busy, done, result, write_reg, write_en, write_data
    );

    modport slave (
        input  start, kill, funct3, operand_a, operand_b, dest_reg,
        output busy, done, result, write_reg, write_en, write_data
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per clock on sign-stripped magnitudes,
// sign fixed up on the last iteration, result written back to the register file on done.
module muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    muldiv_unit_if.slave     bus,
    output logic [1:0]       state_dbg
);
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
    state_t state, state_nx;

    logic [2:0]            op;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       mag_b;
    logic                  neg;
    logic [CNT_W-1:0]      cnt;
    logic [2*XLEN-1:0]     acc, acc_nx;
    logic [XLEN-1:0]       res;

    logic                  is_div_in, a_signed, b_signed, neg_a, neg_b, neg_in;
    logic [XLEN-1:0]       abs_a, abs_b;
    logic                  div_zero, div_ovf, special, start_ok;
    logic [XLEN-1:0]       spec_res;

    logic [XLEN:0]         sum, rem_sh;
    logic [XLEN-1:0]       diff;
    logic                  borrow;
    logic [2*XLEN-1:0]     prod_fix;
    logic [XLEN-1:0]       div_sel, div_fix, fin_res;

    // Operand decode at the accepting edge
    always_comb begin
        is_div_in = bus.funct3[2];
        a_signed  = is_div_in ? ~bus.funct3[0] : (bus.funct3[1:0] == 2'b01 || bus.funct3[1:0] == 2'b10);
        b_signed  = is_div_in ? ~bus.funct3[0] : (bus.funct3[1:0] == 2'b01);
        neg_a     = a_signed & bus.operand_a[XLEN-1];
        neg_b     = b_signed & bus.operand_b[XLEN-1];
        abs_a     = neg_a ? ('0 - bus.operand_a) : bus.operand_a;
        abs_b     = neg_b ? ('0 - bus.operand_b) : bus.operand_b;
        // REM takes the dividend's sign; every other op the product/quotient sign
        neg_in    = (is_div_in && bus.funct3[1]) ? neg_a : (neg_a ^ neg_b);
        div_zero  = is_div_in && (bus.operand_b == '0);
        div_ovf   = is_div_in && !bus.funct3[0] && (bus.operand_a == {1'b1, {(XLEN-1){1'b0}}})
                    && (bus.operand_b == '1);
        special   = div_zero || div_ovf;
        if (div_zero) spec_res = bus.funct3[1] ? bus.operand_a : '1;
        else          spec_res = bus.funct3[1] ? '0 : bus.operand_a;
        start_ok  = (state == IDLE) && bus.start && !bus.kill;
    end

    // One iteration: acc holds {partial, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        sum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? mag_b : '0)};
        rem_sh = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        borrow = rem_sh < {1'b0, mag_b};
        diff   = rem_sh[XLEN-1:0] - mag_b;
        if (!op[2])      acc_nx = {sum, acc[XLEN-1:1]};
        else if (!borrow) acc_nx = {diff, acc[XLEN-2:0], 1'b1};
        else             acc_nx = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        prod_fix = neg ? ('0 - acc_nx) : acc_nx;
        div_sel  = op[1] ? acc_nx[2*XLEN-1:XLEN] : acc_nx[XLEN-1:0];
        div_fix  = neg ? ('0 - div_sel) : div_sel;
        if (op[2])               fin_res = div_fix;
        else if (op[1:0] == 2'b00) fin_res = prod_fix[XLEN-1:0];
        else                     fin_res = prod_fix[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start_ok) state_nx = special ? DONE : CALC;
            CALC: begin
                if (bus.kill)                          state_nx = IDLE;
                else if (cnt == CNT_W'(XLEN - 1))      state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op    <= '0;
            rd    <= '0;
            mag_b <= '0;
            neg   <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            res   <= '0;
        end else if (start_ok) begin
            op    <= bus.funct3;
            rd    <= bus.dest_reg;
            mag_b <= abs_b;
            neg   <= neg_in;
            cnt   <= '0;
            acc   <= {{XLEN{1'b0}}, abs_a};
            if (special) res <= spec_res;
        end else if (state == CALC && !bus.kill) begin
            acc <= acc_nx;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(XLEN - 1)) res <= fin_res;
        end
    end

    always_comb begin
        bus.busy       = (state != IDLE);
        bus.done       = (state == DONE);
        bus.write_en   = (state == DONE) && (rd != '0);
        bus.write_reg  = rd;
        bus.result     = res;
        bus.write_data = res;
        state_dbg      = state;
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: driver pushes expected writes, negedge monitor pops and compares.
module tb_muldiv_unit;
  localparam int EW = 46;  // {latency[7:0], write_en, write_reg[4:0], result[31:0]}

  logic clk = 1'b0;
  logic rst;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

  muldiv_unit #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_fail = 0;
  int n_push = 0;
  int n_done = 0;
  int edge_cnt = 0;
  int start_edge = 0;
  logic [31:0] last_res = '0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin : mon
    logic [EW-1:0] e;
    if (rst === 1'b0 && bus.done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_done: got result %h, expected no done", bus.result);
      end else begin
        e = exp_q.pop_front();
        cmp("result", bus.result, e[31:0]);
        cmp("write_data", bus.write_data, e[31:0]);
        cmp("write_reg", 32'(bus.write_reg), 32'(e[36:32]));
        cmp("write_en", 32'(bus.write_en), 32'(e[37]));
        cmp("latency", 32'(edge_cnt - start_edge), 32'(e[45:38]));
      end
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    bus.funct3 = f3;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.dest_reg = rd;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    start_edge = edge_cnt;
    bus.start = 1'b0;
    bus.operand_a = $urandom;
    bus.operand_b = $urandom;
    bus.dest_reg = 5'($urandom_range(0, 31));
    cmp("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++;
      n_fail++;
      $display("FAIL done_timeout: got no done in 40 cycles, expected done");
    end
    @(negedge clk);
    cmp("busy_after_done", 32'(bus.busy), 32'd0);
    cmp("done_pulse_width", 32'(bus.done), 32'd0);
    cmp("write_en_after_done", 32'(bus.write_en), 32'd0);
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] res, input int lat,
                        input bit mid_pulse);
    logic wen;
    wen = (rd != 5'd0);
    exp_q.push_back({8'(lat), wen, rd, res});
    n_push++;
    last_res = res;
    issue(f3, a, b, rd);
    if (mid_pulse) begin
      repeat (5) @(negedge clk);
      bus.funct3 = 3'b100;
      bus.operand_a = 32'd1;
      bus.operand_b = 32'd0;
      bus.dest_reg = 5'd31;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    wait_done();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.kill = 1'b0;
    bus.funct3 = 3'b000;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.dest_reg = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmp("reset_busy", 32'(bus.busy), 32'd0);
    cmp("reset_done", 32'(bus.done), 32'd0);
    cmp("reset_write_en", 32'(bus.write_en), 32'd0);
    cmp("reset_result", bus.result, 32'd0);
    cmp("reset_write_reg", 32'(bus.write_reg), 32'd0);
    cmp("reset_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // multiply family
    run_op(3'b000, 32'd12983,     32'd324,       5'd10, 32'd4206492,   32, 1'b0);
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000, 32, 1'b0);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 32, 1'b0);
    run_op(3'b010, 32'hFFFF_FFFF, 32'd2,         5'd3,  32'hFFFF_FFFF, 32, 1'b0);
    run_op(3'b001, 32'hFFFF_FFFD, 32'd5,         5'd18, 32'hFFFF_FFFF, 32, 1'b0);
    // divide family
    run_op(3'b100, 32'hFFFF_FFEC, 32'd3,         5'd4,  32'hFFFF_FFFA, 32, 1'b0);
    run_op(3'b110, 32'hFFFF_FFEC, 32'd3,         5'd5,  32'hFFFF_FFFE, 32, 1'b0);
    run_op(3'b101, 32'd20,        32'd3,         5'd6,  32'd6,         32, 1'b0);
    run_op(3'b111, 32'd20,        32'd3,         5'd7,  32'd2,         32, 1'b0);
    run_op(3'b100, 32'd7,         32'hFFFF_FFFE, 5'd19, 32'hFFFF_FFFD, 32, 1'b0);
    run_op(3'b110, 32'd7,         32'hFFFF_FFFE, 5'd20, 32'd1,         32, 1'b0);
    // special cases: straight to done
    run_op(3'b100, 32'd500,       32'd0,         5'd8,  32'hFFFF_FFFF, 0, 1'b0);
    run_op(3'b110, 32'd500,       32'd0,         5'd9,  32'd500,       0, 1'b0);
    run_op(3'b101, 32'd9,         32'd0,         5'd21, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(3'b111, 32'd7,         32'd0,         5'd22, 32'd7,         0, 1'b0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 0, 1'b0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,         0, 1'b0);
    // rd=0 suppresses write; a second start mid-CALC is ignored
    run_op(3'b000, 32'd7,         32'hFFFF_FFFD, 5'd0,  32'hFFFF_FFEB, 32, 1'b1);

    // reset in the middle of CALC discards the operation
    issue(3'b000, 32'd5, 32'd6, 5'd13);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    cmp("midrst_busy", 32'(bus.busy), 32'd0);
    cmp("midrst_done", 32'(bus.done), 32'd0);
    cmp("midrst_write_en", 32'(bus.write_en), 32'd0);
    cmp("midrst_result", bus.result, 32'd0);
    cmp("midrst_write_reg", 32'(bus.write_reg), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_res = '0;

    run_op(3'b101, 32'd100, 32'd7, 5'd15, 32'd14, 32, 1'b0);

    // kill during CALC: back to IDLE, no done, result held
    issue(3'b111, 32'd100, 32'd7, 5'd16);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.kill = 1'b1;
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    cmp("kill_busy", 32'(bus.busy), 32'd0);
    cmp("kill_done", 32'(bus.done), 32'd0);
    cmp("kill_result_held", bus.result, last_res);
    repeat (40) @(negedge clk);

    run_op(3'b110, 32'd100, 32'hFFFF_FFF9, 5'd17, 32'd2, 32, 1'b0);

    // kill together with start in IDLE: start dropped
    @(negedge clk);
    bus.funct3 = 3'b000;
    bus.operand_a = 32'd3;
    bus.operand_b = 32'd4;
    bus.dest_reg = 5'd23;
    bus.start = 1'b1;
    bus.kill = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.kill = 1'b0;
    cmp("kill_start_busy", 32'(bus.busy), 32'd0);
    repeat (40) @(negedge clk);

    cmp("queue_empty", 32'(exp_q.size()), 32'd0);
    cmp("done_count", 32'(n_done), 32'(n_push));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Sits directly downstream of the register file and consumes its two read-data outputs as operands.
- Drives a write request (register address, data, enable) back into the register-file write port when the result is ready.
- Core stalls on busy; one operation in flight at a time.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
REG_ADDR_W, 5, destination register address width

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
kill  input  1  synchronous abort of in-flight operation
funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
operand_a  input  XLEN  rs1 value (register file read_data1)
operand_b  input  XLEN  rs2 value (register file read_data2)
dest_reg  input  REG_ADDR_W  rd address
busy  output  1  high while not IDLE (CALC or DONE)
done  output  1  one-cycle pulse, result valid
result  output  XLEN  registered result; holds last value until next DONE
write_reg  output  REG_ADDR_W  latched rd, to register-file write_reg
write_en  output  1  done && write_reg != 0
write_data  output  XLEN  equals result

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, write_en=0, result=0, write_reg=0, iteration counter=0. Reset mid-CALC discards the operation; no write is issued.
- States: IDLE, CALC, DONE.
- IDLE + start at edge E0:
  - Latch funct3, dest_reg, and sign-adjusted magnitudes of both operands.
  - Record result sign.
  - Clear counter.
  - Go to CALC, or directly to DONE on a special case.
- Operand signedness:
  - MULH and DIV/REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MUL, MULHU, DIVU, REMU: both unsigned. MUL low word is sign-independent.
- CALC performs one iteration per clock, 32 iterations:
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract producing a 32-bit quotient and remainder.
  - After the 32nd iteration (edge E32), apply the sign correction, register result, and go to DONE.
- Result selection: MUL = low 32 bits of the product; MULH/MULHSU/MULHU = high 32 bits. DIV sign = sign(a) xor sign(b); REM sign = sign(a).
- DONE lasts one cycle: done=1, write_en as defined, busy=1. Next edge returns to IDLE.
- Normal latency: done is high in the 32nd cycle after the start edge. A new start is accepted in the cycle after DONE.
- Special cases (E0 goes straight to DONE; done in the cycle after E0):
  - Divisor 0: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU result = operand_a.
  - Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): DIV = 0x80000000, REM = 0.
- start while busy is ignored; operand changes after E0 are ignored.
- kill (CALC or DONE) at an edge: state=IDLE, done=0, write_en=0; result retains its previous value. kill in IDLE has no effect. kill and start together in IDLE: kill wins, start is dropped.
- dest_reg=0: the operation runs normally and done pulses, but write_en stays 0.

Test Plan:
- MUL a=12983, b=324, rd=10, start -> done exactly 32 cycles after the start edge; result=4206492; write_en=1, write_reg=10; busy falls the following cycle.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000. MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=-1, b=2 -> 0xFFFFFFFF.
- DIV a=-20, b=3 -> -6; REM -> -2; DIVU a=20, b=3 -> 6; REMU -> 2; each done 32 cycles after start.
- DIV a=500, b=0 -> 0xFFFFFFFF and REM -> 500, both done 1 cycle after start. DIV a=0x80000000, b=-1 -> 0x80000000; REM -> 0.
- Start MUL with rd=0 -> done pulses, write_en stays 0. Pulse start again during CALC -> ignored; done pulses only once.
- Assert rst at cycle 10 of CALC -> all outputs 0 immediately, no write_en. Assert kill at cycle 5 -> IDLE, no done; a subsequent fresh start completes normally.
